uart_tx_fifo: RTL

Parametrised UART transmitter with an internal transmit FIFO and a valid/ready write interface. Frame format (data bits, parity, stop bits) and baud rate are set at elaboration. Producers (CPU MMIO store path, debug printers) push bytes without polling line timing. Queued frames go out back-to-back on a single TX line, with no idle gap between them.

---
 rtl/uart_tx_fifo.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/uart_tx_fifo.sv
// UART transmitter fed from a small FIFO with a valid/ready write port.
// Queued frames leave back-to-back; the line output is registered, so it trails the FSM state by one cycle.
module uart_tx_fifo #(
  parameter int FREQ       = 27000000,
  parameter int BAUD       = 115200,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          valid_i,
  input  logic [DATA_BITS-1:0]          data_i,
  output logic                          ready_o,
  output logic                          uart_tx_o,
  output logic                          busy_o,
  output logic [$clog2(FIFO_DEPTH):0]   level_o
);

  localparam int DIV = FREQ / BAUD;
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int PW  = $clog2(FIFO_DEPTH);
  localparam int LW  = PW + 1;
  localparam int BW  = $clog2(DATA_BITS + 1);

  generate
    if (DIV < 2) begin : g_div_chk
      $error("uart_tx_fifo: FREQ/BAUD must be at least 2");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bits_chk
      $error("uart_tx_fifo: DATA_BITS must be 5..9");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_par_chk
      $error("uart_tx_fifo: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_stop_chk
      $error("uart_tx_fifo: STOP_BITS must be 1 or 2");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_depth_chk
      $error("uart_tx_fifo: FIFO_DEPTH must be a power of two >= 2");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP
  } state_e;

  state_e               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic                 par_q, par_d;
  logic                 tx_q, tx_d;
  logic                 busy_q, busy_d;
  logic [LW-1:0]        level_q, level_d;
  logic [PW-1:0]        wr_q, wr_d, rd_q, rd_d;
  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [DATA_BITS-1:0] mem_d [FIFO_DEPTH];

  logic push, pop, bit_end, last_stop;

  assign ready_o   = (level_q != LW'(FIFO_DEPTH));
  assign push      = valid_i && ready_o;
  assign bit_end   = (cnt_q == CW'(DIV - 1));
  assign last_stop = (state_q == S_STOP) && bit_end && (bit_q == BW'(STOP_BITS - 1));
  assign pop       = (level_q != '0) && ((state_q == S_IDLE) || last_stop);

  always_comb begin
    mem_d   = mem_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    level_d = level_q;
    state_d = state_q;
    cnt_d   = bit_end ? '0 : cnt_q + CW'(1);
    bit_d   = bit_q;
    shreg_d = shreg_q;
    par_d   = par_q;

    if (push) begin
      mem_d[wr_q] = data_i;
      wr_d        = wr_q + PW'(1);
    end
    if (pop) rd_d = rd_q + PW'(1);

    case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (pop) state_d = S_START;
      end
      S_START: begin
        if (bit_end) begin
          state_d = S_DATA;
          bit_d   = '0;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          shreg_d = shreg_q >> 1;
          if (bit_q == BW'(DATA_BITS - 1)) begin
            bit_d   = '0;
            state_d = (PARITY != 0) ? S_PARITY : S_STOP;
          end else begin
            bit_d = bit_q + BW'(1);
          end
        end
      end
      S_PARITY: begin
        if (bit_end) begin
          state_d = S_STOP;
          bit_d   = '0;
        end
      end
      S_STOP: begin
        if (last_stop) begin
          bit_d   = '0;
          state_d = pop ? S_START : S_IDLE;
        end else if (bit_end) begin
          bit_d = bit_q + BW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Frame payload and its parity are latched together at pop time.
    if (pop) begin
      shreg_d = mem_q[rd_q];
      par_d   = (^mem_q[rd_q]) ^ (PARITY == 1);
    end

    case (state_q)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shreg_q[0];
      S_PARITY: tx_d = par_q;
      default:  tx_d = 1'b1;
    endcase

    busy_d = (state_d != S_IDLE) || (level_d != '0);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      level_q <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      level_q <= level_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
    end
  end

  // Storage needs no reset; occupancy is tracked by the pointers and level.
  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

  assign uart_tx_o = tx_q;
  assign busy_o    = busy_q;
  assign level_o   = level_q;

endmodule
